// File: rtl/sram_controller_pkg.sv
// Shared constants and FSM encoding for the external SRAM controller.
package sram_controller_pkg;

  localparam int          SRAM_AW     = 17;
  localparam int          DATA_W      = 32;
  localparam int          BUS_W       = 64;
  localparam int          WAIT_CYCLES = 5;
  localparam logic [31:0] BASE_ADDR   = 32'd1024;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts 0..N-1 while enabled, flags the last count.
module sram_wait_counter #(
  parameter int N = 5,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = en && (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage initiator for the 64-bit-read / 32-bit-write SRAM.
// Freezes the pipeline with ready low until each access completes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES =
    sram_controller_pkg::WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR =
    sram_controller_pkg::BASE_ADDR,
  parameter int SRAM_AW =
    sram_controller_pkg::SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  inout  wire  [BUS_W-1:0]   SRAM_DQ
);

  state_t state;
  state_t state_nx;

  logic [31:0]        diff;
  logic [SRAM_AW-1:0] word_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               busy;
  logic               tc;
  logic               unused_diff;

  // Offset from the SRAM window; upper bits wrap away silently.
  assign diff        = address - BASE_ADDR;
  assign unused_diff = ^{diff[31:SRAM_AW+2], diff[1:0]};

  assign busy = (state == ST_READ) || (state == ST_WRITE);

  sram_wait_counter #(
    .N (WAIT_CYCLES)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .clr (!busy),
    .tc  (tc)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (wr_en) begin
          state_nx = ST_WRITE;
        end else if (rd_en) begin
          state_nx = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (tc) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && (wr_en || rd_en)) begin
        word_q <= diff[SRAM_AW+1:2];
      end
      if (state == ST_IDLE && wr_en) begin
        wdata_q <= write_data;
      end
      // Odd word lives in the upper half of the 64-bit read.
      if (state == ST_READ && tc) begin
        read_data <= word_q[0] ? SRAM_DQ[63:32]
                               : SRAM_DQ[31:0];
      end
    end
  end

  assign ready = (state == ST_DONE) ||
                 (state == ST_IDLE && !rd_en && !wr_en);

  assign SRAM_WE_N = (state != ST_WRITE);
  assign SRAM_ADDR = (state == ST_IDLE) ? '0 : word_q;
  assign SRAM_DQ   = SRAM_WE_N ? {BUS_W{1'bz}}
                               : {32'b0, wdata_q};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM device model plus a word-level
// reference memory; directed cases followed by random accesses.
module tb_sram_controller;

  localparam int WAIT = 5;
  localparam int AW   = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE_N;
  wire  [63:0]   SRAM_DQ;

  logic [31:0] sram_mem [0:(1<<AW)-1];
  bit   [31:0] ref_mem [int];
  logic [31:0] exp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  sram_controller #(
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_DQ    (SRAM_DQ)
  );

  // SRAM device: reads return the aligned word pair, writes take [31:0].
  assign SRAM_DQ = SRAM_WE_N
    ? {sram_mem[{SRAM_ADDR[AW-1:1], 1'b1}],
       sram_mem[{SRAM_ADDR[AW-1:1], 1'b0}]}
    : 64'bz;

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ[31:0];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - 32'd1024) / 4) % 32'h20000;
    return w[AW-1:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return 32'h0;
  endfunction

  task automatic do_access(input bit r, input bit w,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input bit jitter,
                           output int freeze);
    logic [AW-1:0] wd;
    int we_low, bad_addr, bad_dq;
    bit got;
    wd = word_of(a);
    rd_en = r; wr_en = w;
    address = a; write_data = d;
    freeze = 0; we_low = 0;
    bad_addr = 0; bad_dq = 0; got = 0;
    for (int c = 0; c < 4*WAIT + 8 && !got; c++) begin
      @(negedge clk);
      if (!SRAM_WE_N) begin
        we_low++;
        if (SRAM_ADDR !== wd) bad_addr++;
        if (SRAM_DQ !== {32'b0, d}) bad_dq++;
      end
      if (ready) begin
        got = 1;
      end else begin
        freeze++;
        @(posedge clk); #1;
        if (jitter) begin
          address    = $urandom;
          write_data = $urandom;
          rd_en      = 1'($urandom);
          wr_en      = 1'($urandom);
        end
      end
    end
    check("ready_seen", 64'(got), 1);
    check("freeze", 64'(freeze), WAIT + 1);
    check("we_low", 64'(we_low), w ? WAIT : 0);
    check("wr_addr", 64'(bad_addr), 0);
    check("wr_dq", 64'(bad_dq), 0);
    check("done_addr", 64'(SRAM_ADDR), 64'(wd));
    if (w) ref_mem[int'(wd)] = d;
    else exp_rdata = ref_read(wd);
    check("rdata", 64'(read_data), 64'(exp_rdata));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 1);
    check("idle_addr", 64'(SRAM_ADDR), 0);
    check("idle_we_n", 64'(SRAM_WE_N), 1);
    check("idle_bus", SRAM_DQ, {sram_mem[1], sram_mem[0]});
    @(posedge clk); #1;
  endtask

  initial begin
    int f1, f2, kind;
    logic [31:0] a, d;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 32'h0;
    rst = 1; rd_en = 1; wr_en = 0;
    address = 0; write_data = 0;
    exp_rdata = 0;

    // Reset with a pending read
    repeat (2) @(posedge clk);
    #1;
    check("rst_we_n", 64'(SRAM_WE_N), 1);
    check("rst_rdata", 64'(read_data), 0);
    check("rst_addr", 64'(SRAM_ADDR), 0);
    check("rst_ready_rd", 64'(ready), 0);
    rd_en = 0;
    #1;
    check("rst_ready", 64'(ready), 1);
    rst = 0;
    @(posedge clk); #1;

    // Directed writes and reads
    do_access(0, 1, 32'd1024, 32'hDEADBEEF, 0, f1);
    check("mem_w0", 64'(sram_mem[0]), 64'hDEADBEEF);
    idle();
    do_access(0, 1, 32'd1028, 32'h12345678, 0, f1);
    idle();
    do_access(1, 0, 32'd1028, 32'h0, 0, f1);
    check("rd_hi", 64'(read_data), 64'h12345678);
    idle();
    do_access(1, 0, 32'd1024, 32'h0, 0, f1);
    check("rd_lo", 64'(read_data), 64'hDEADBEEF);
    idle();

    // Back-to-back reads, request held across DONE
    do_access(1, 0, 32'd1028, 32'h0, 0, f1);
    do_access(1, 0, 32'd1024, 32'h0, 0, f2);
    check("b2b_freeze", 64'(f1 + f2), 12);
    idle();

    // Reset in the middle of a read
    rd_en = 1; address = 32'd1028;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 64'(ready), 0);
    rst = 1; rd_en = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_rdata = 0;
    check("mid_we_n", 64'(SRAM_WE_N), 1);
    check("mid_rdata", 64'(read_data), 0);
    check("mid_addr", 64'(SRAM_ADDR), 0);
    check("mid_ready", 64'(ready), 1);
    @(posedge clk); #1;
    check("mid_no_done", 64'(SRAM_ADDR), 0);
    do_access(1, 0, 32'd1028, 32'h0, 0, f1);
    idle();

    // Simultaneous request: write wins; wrapped address
    do_access(1, 1, 32'd1032, 32'hA5A5A5A5, 0, f1);
    check("both_mem", 64'(sram_mem[2]), 64'hA5A5A5A5);
    idle();
    do_access(1, 0, 32'd1024 + 32'd4 * 32'h20000,
              32'h0, 0, f1);
    check("wrap_rd", 64'(read_data), 64'hDEADBEEF);
    idle();

    // Random traffic with request jitter while busy
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      a = 32'd1024 + 32'd4 * $urandom_range(0, 7);
      if (kind == 1) a = a + 32'd4 * 32'h20000 *
                         $urandom_range(1, 3);
      if (kind == 2) a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 3))
        0, 1: do_access(1, 0, a, d, 1, f1);
        2:    do_access(0, 1, a, d, 1, f1);
        default: do_access(1, 1, a, d, 1, f1);
      endcase
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
